// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream (word-count header, then words)
// into 32-bit instruction-memory writes, holding core_rst until the image is in place.
// Optional trailing XOR checksum byte when CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wd,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state, state_n;
  logic [1:0]          bcnt, bcnt_n;
  logic [31:0]         word, word_n;
  logic [31:0]         assembled;
  logic [7:0]          csum, csum_n;
  logic [ADDR_WIDTH:0] count, count_n;
  logic [ADDR_WIDTH:0] wl_n;
  logic [31:0]         mem_addr_n, mem_wd_n;
  logic                mem_we_n;
  logic                fire, last_byte;

  assign fire      = rx_valid && rx_ready;
  assign last_byte = (bcnt == 2'd3);
  // New byte enters at the top so the first byte ends up in [7:0] after four shifts.
  assign assembled = {rx_data, word[31:8]};

  always_comb begin
    state_n    = state;
    bcnt_n     = bcnt;
    word_n     = word;
    csum_n     = csum;
    count_n    = count;
    wl_n       = words_loaded;
    mem_we_n   = 1'b0;
    mem_addr_n = mem_addr;
    mem_wd_n   = mem_wd;
    case (state)
      S_HDR: begin
        if (fire) begin
          word_n = assembled;
          bcnt_n = bcnt + 2'd1;
          if (last_byte) begin
            if (assembled == 32'd0) begin
              state_n = S_DONE;
            end else if ({1'b0, assembled} > DEPTH) begin
              state_n = S_ERR;
            end else begin
              state_n = S_DATA;
              count_n = assembled[ADDR_WIDTH:0];
            end
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          word_n = assembled;
          bcnt_n = bcnt + 2'd1;
          csum_n = csum ^ rx_data;
          if (last_byte) begin
            state_n    = S_WRITE;
            mem_we_n   = 1'b1;
            mem_wd_n   = assembled;
            mem_addr_n = BASE_ADDR + (32'(words_loaded) << 2);
            wl_n       = words_loaded + (ADDR_WIDTH+1)'(1);
          end
        end
      end
      S_WRITE: begin
        // words_loaded already counts the word being written this cycle
        if (words_loaded == count) begin
`ifdef CHECKSUM_EN
          state_n = S_CHK;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_DATA;
        end
      end
      S_CHK: begin
        if (fire) begin
          state_n = (rx_data == csum) ? S_DONE : S_ERR;
        end
      end
      default: begin
        state_n = state;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= S_HDR;
      bcnt         <= 2'd0;
      csum         <= 8'd0;
      count        <= '0;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wd       <= 32'd0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_n;
      bcnt         <= bcnt_n;
      csum         <= csum_n;
      count        <= count_n;
      rx_ready     <= (state_n == S_HDR) || (state_n == S_DATA) || (state_n == S_CHK);
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      mem_wd       <= mem_wd_n;
      core_rst     <= (state_n != S_DONE);
      done         <= (state_n == S_DONE);
      error        <= (state_n == S_ERR);
      words_loaded <= wl_n;
    end
  end

  always_ff @(posedge CLK) begin
    word <= word_n;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a load-level reference model queues the expected
// memory writes, and an independent monitor checks each mem_we pulse against the queue.
module tb_imem_loader;
  localparam int          AW    = 4;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF0;
`ifdef CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, mem_we, core_rst, done, error;
  logic [31:0]   mem_addr, mem_wd;
  logic [AW:0]   words_loaded;

  imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .core_rst(core_rst),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          wl;
  } wr_t;

  wr_t         expq[$];
  logic [31:0] img[$];
  int          checks = 0;
  int          errors = 0;
  bit          toggle_mode = 1'b0;
  bit          held = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next write the model predicted.
  always @(negedge CLK) begin
    if (mem_we) begin
      if (expq.size() == 0) begin
        chk("write_when_none_expected", 64'(expq.size()), 64'd1);
      end else begin
        wr_t w;
        w = expq.pop_front();
        chk("write_addr", mem_addr, w.addr);
        chk("write_data", mem_wd, w.data);
        chk("write_words_loaded", 64'(words_loaded), 64'(w.wl));
        chk("write_rx_ready_low", 64'(rx_ready), 64'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 100) begin
      @(negedge CLK);
      rx_data = b;
      if (held) rx_valid = 1'b1;
      else if (toggle_mode) rx_valid = ~rx_valid;
      else rx_valid = ($urandom_range(0, 3) != 0);
      acc  = rx_valid && rx_ready;
      held = rx_valid && !rx_ready;
      n++;
    end
    if (!acc) chk("byte_accept_timeout", 64'(n), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1;
    rx_valid = 1'b0;
    held = 1'b0;
    repeat (2) @(negedge CLK);
    expq.delete();
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wd", mem_wd, 64'd0);
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_words_loaded", 64'(words_loaded), 64'd0);
    rst = 1'b0;
  endtask

  // Whole-load reference: header count decides outcome; each word i lands at BASE+4i.
  task automatic run_load(input logic [31:0] cnt, input bit bad_csum, input bit toggle);
    logic [7:0] cs = 8'h00;
    bit         writes, expect_err;
    int         lat, k, late;
    do_reset();
    toggle_mode = toggle;
    writes     = (cnt != 0) && (cnt <= 32'(DEPTH));
    expect_err = (cnt > 32'(DEPTH)) || (writes && CSUM_ON && bad_csum);
    if (writes) begin
      for (int i = 0; i < int'(cnt); i++) begin
        expq.push_back('{BASE + 32'(i) * 32'd4, img[i], i + 1});
        for (int b = 0; b < 4; b++) cs ^= img[i][8*b +: 8];
      end
    end
    lat = (writes && !CSUM_ON) ? 2 : 1;
    for (int b = 0; b < 4; b++) send_byte(cnt[8*b +: 8]);
    if (writes) begin
      for (int i = 0; i < int'(cnt); i++)
        for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8]);
      if (CSUM_ON) send_byte(bad_csum ? (cs ^ 8'h01) : cs);
    end
    k = 0;
    do begin
      @(negedge CLK);
      rx_valid = 1'b0;
      held = 1'b0;
      k++;
    end while (!(done || error) && k < 50);
    chk("finish_latency", 64'(k), 64'(lat));
    chk("end_done", 64'(done), 64'(!expect_err));
    chk("end_error", 64'(error), 64'(expect_err));
    chk("end_core_rst", 64'(core_rst), 64'(expect_err));
    chk("end_rx_ready", 64'(rx_ready), 64'd0);
    chk("end_words_loaded", 64'(words_loaded), writes ? 64'(cnt) : 64'd0);
    chk("end_pending_writes", 64'(expq.size()), 64'd0);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    late = 0;
    repeat (4) begin
      @(negedge CLK);
      late += int'(rx_ready);
    end
    rx_valid = 1'b0;
    chk("late_byte_ready", 64'(late), 64'd0);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    img = '{32'h0050_0093, 32'h0010_0113};
    run_load(32'd2, 1'b0, 1'b0);
    run_load(32'd0, 1'b0, 1'b0);
    run_load(32'd17, 1'b0, 1'b0);
    run_load(32'h8000_0010, 1'b0, 1'b0);
    img = '{32'h0050_0093, 32'h0010_0113};
    run_load(32'd2, 1'b0, 1'b1);
    // reset after header and two data bytes, then a clean load
    do_reset();
    toggle_mode = 1'b0;
    for (int b = 0; b < 4; b++) send_byte(b == 0 ? 8'h02 : 8'h00);
    send_byte(8'h93);
    send_byte(8'h00);
    run_load(32'd2, 1'b0, 1'b0);
    run_load(32'd2, 1'b1, 1'b0);
    rand_img(DEPTH);
    run_load(32'(DEPTH), 1'b0, 1'b0);
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      rand_img(n);
      run_load(32'(n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
